// File: rtl/lsnn_neuron_array_if.sv
// Timestep handshake between the spike-input front end, the neuron array and
// the spike-output port. The input side is a valid/ready pair carrying one
// packed word of per-neuron currents. The output side is a one-cycle valid
// pulse that comes with the spike vector.
interface lsnn_neuron_array_if #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [N_NEURONS*WIDTH-1:0] in_data;
  logic                       out_valid;
  logic [N_NEURONS-1:0]       out_spikes;

  // Front end / consumer side
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_spikes
  );

  // Neuron array side
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_spikes
  );
endinterface

// File: rtl/lsnn_neuron_array.sv
// Array of adaptive leaky integrate-and-fire neurons that share one datapath.
// After each accepted timestep the neurons are updated one per cycle, and the
// spike vector is published with a one-cycle out_valid pulse. Any neuron's
// live threshold can be read on th_out for debug.
// Optional feature: define LSNN_REFRACTORY_EN to add a refractory counter per
// neuron. A neuron then stays silent for REFRACT steps after it spikes.
module lsnn_neuron_array #(
  parameter int N_NEURONS         = 4,
  parameter int WIDTH             = 8,
  parameter int LEAK_SHIFT        = 1,
  parameter int B0                = 8,
  parameter int A_INIT            = 8,
  parameter int ADAPT_INC         = 4,
  parameter int ADAPT_DECAY_SHIFT = 2,
  parameter int REFRACT           = 2,
  localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  lsnn_neuron_array_if.slave bus,
  input  logic             clr_state,
  input  logic [IDX_W-1:0] th_sel,
  output logic [WIDTH-1:0] th_out
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [WIDTH-1:0] B0_W     = WIDTH'(B0);
  localparam logic [WIDTH-1:0] A_INIT_W = WIDTH'(A_INIT);
  localparam logic [WIDTH-1:0] INC_W    = WIDTH'(ADAPT_INC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  // Saturating unsigned add; clamps at all-ones.
  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  endfunction

  logic [0:0]                 state;
  logic [IDX_W-1:0]           idx;
  logic [N_NEURONS*WIDTH-1:0] in_buf;
  logic [N_NEURONS-1:0]       shadow;
  logic [N_NEURONS-1:0]       shadow_next;
  logic [N_NEURONS-1:0]       out_spikes_q;
  logic                       out_valid_q;

  logic [WIDTH-1:0] v_q [N_NEURONS];
  logic [WIDTH-1:0] a_q [N_NEURONS];

  logic [WIDTH-1:0] x_cur;
  logic [WIDTH-1:0] v_cur;
  logic [WIDTH-1:0] a_cur;
  logic [WIDTH-1:0] a_decay;
  logic [WIDTH-1:0] s_cur;
  logic [WIDTH-1:0] th_cur;
  logic [WIDTH-1:0] v_next;
  logic [WIDTH-1:0] a_next;
  logic             spike;

`ifdef LSNN_REFRACTORY_EN
  localparam int R_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [R_W-1:0] R_LOAD = R_W'(REFRACT);
  logic [R_W-1:0] r_q [N_NEURONS];
  logic [R_W-1:0] r_next;
`else
  // The refractory length has no effect in this build.
  logic unused_refract;
  assign unused_refract = ^32'(REFRACT);
`endif

  assign bus.in_ready   = (state == IDLE) && !clr_state;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_spikes = out_spikes_q;

  // Neuron update for the neuron selected by idx, using its pre-update state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    x_cur   = in_buf[int'(idx)*WIDTH +: WIDTH];
    v_cur   = v_q[idx];
    a_cur   = a_q[idx];
    a_decay = a_cur - (a_cur >> ADAPT_DECAY_SHIFT);
    s_cur   = sat_add(x_cur, v_cur - (v_cur >> LEAK_SHIFT));
    th_cur  = sat_add(B0_W, a_cur);
    spike   = (s_cur >= th_cur);
    v_next  = spike ? '0 : s_cur;
    a_next  = spike ? sat_add(a_cur, INC_W) : a_decay;
`ifdef LSNN_REFRACTORY_EN
    r_next  = spike ? R_LOAD : '0;
    if (r_q[idx] != '0) begin
      spike  = 1'b0;
      v_next = '0;
      a_next = a_decay;
      r_next = r_q[idx] - 1'b1;
    end
`endif
    shadow_next      = shadow;
    shadow_next[idx] = spike;
  end

  // Debug threshold view; a select beyond the array reads as zero.
  always_comb begin
    th_out = '0;
    if (int'(th_sel) < N_NEURONS) th_out = sat_add(B0_W, a_q[th_sel]);
  end

  // Timestep FSM and serial update of the per-neuron state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      in_buf       <= '0;
      shadow       <= '0;
      out_spikes_q <= '0;
      out_valid_q  <= 1'b0;
      // NOTE: the neuron state is a register file, not a RAM, so every entry is reset here.
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i] <= '0;
        a_q[i] <= A_INIT_W;
`ifdef LSNN_REFRACTORY_EN
        r_q[i] <= '0;
`endif
      end
    end else begin
      // NOTE: state registers use non-blocking assignments, so every read in this block sees values from before the edge.
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_state) begin
            for (int i = 0; i < N_NEURONS; i++) begin
              v_q[i] <= '0;
              a_q[i] <= A_INIT_W;
`ifdef LSNN_REFRACTORY_EN
              r_q[i] <= '0;
`endif
            end
          end else if (bus.in_valid) begin
            in_buf <= bus.in_data;
            idx    <= '0;
            state  <= BUSY;
          end
        end
        default: begin
          v_q[idx] <= v_next;
          a_q[idx] <= a_next;
`ifdef LSNN_REFRACTORY_EN
          r_q[idx] <= r_next;
`endif
          shadow <= shadow_next;
          if (idx == LAST_IDX) begin
            state        <= IDLE;
            out_spikes_q <= shadow_next;
            out_valid_q  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsnn_neuron_array.sv
// Directed bench for lsnn_neuron_array with default parameters. Expected
// values are worked out by hand from the neuron equations. The refractory
// scenario follows whichever build is compiled (LSNN_REFRACTORY_EN).
module tb_lsnn_neuron_array;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr_state = 1'b0;
  logic [1:0]   th_sel = 2'd0;
  logic [W-1:0] th_out;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  lsnn_neuron_array_if #(.N_NEURONS(N), .WIDTH(W)) bus ();

  lsnn_neuron_array #(.N_NEURONS(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_state (clr_state),
    .th_sel    (th_sel),
    .th_out    (th_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic get_th(input int sel, output logic [W-1:0] t);
    th_sel = 2'(sel);
    #1;
    t = th_out;
  endtask

  // Start at a negedge with the DUT idle; return at the negedge where out_valid is seen.
  task automatic do_step(input logic [31:0] data, output logic [N-1:0] sp);
    bit seen;
    seen = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("step_timeout", 32'd0, 32'd1);
    sp = bus.out_spikes;
  endtask

  task automatic pulse_clr();
    clr_state = 1'b1;
    @(negedge clk);
    clr_state = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] sp;
    logic [W-1:0] t;
    bit           ov_seen;
    int           spike_cnt;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state, observed while reset is still asserted
    #12;
    check("rst_th_out", th_out, 16);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_spikes", bus.out_spikes, 0);
    check("rst_out_valid", bus.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // One timestep, x=5 on neuron 0: cycle-accurate handshake timing
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0005;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      check($sformatf("busy_out_valid_%0d", e), bus.out_valid, 0);
      check($sformatf("busy_in_ready_%0d", e), bus.in_ready, 0);
    end
    @(negedge clk);
    check("done_out_valid", bus.out_valid, 1);
    check("done_in_ready", bus.in_ready, 1);
    check("done_spikes", bus.out_spikes, 0);
    get_th(0, t);
    check("x5_th0", t, 14);
    get_th(3, t);
    check("x5_th3", t, 14);
    @(negedge clk);
    check("pulse_one_cycle", bus.out_valid, 0);

    // clr_state together with in_valid: no accept, state back to v=0, a=8
    clr_state    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF_FFFF;
    #1;
    check("clr_in_ready", bus.in_ready, 0);
    @(negedge clk);
    clr_state    = 1'b0;
    bus.in_valid = 1'b0;
    ov_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen = 1'b1;
    end
    check("clr_no_accept", ov_seen, 0);
    for (int i = 0; i < N; i++) begin
      get_th(i, t);
      check($sformatf("clr_th%0d", i), t, 16);
    end
    // v0 was 5 before the clear: with it still there, x=14 would reach 17 and spike
    do_step(32'h0000_000E, sp);
    check("clr_v_zero", sp, 4'b0000);
    pulse_clr();

    // Neuron 0: x=20 followed by three steps of x=200
    do_step(32'h0000_0014, sp);
    check("ad_s1_spikes", sp, 4'b0001);
    get_th(0, t);
    check("ad_s1_th", t, 20);
`ifdef LSNN_REFRACTORY_EN
    do_step(32'h0000_00C8, sp);
    check("rf_s2_spikes", sp, 4'b0000);
    get_th(0, t);
    check("rf_s2_th", t, 17);
    do_step(32'h0000_00C8, sp);
    check("rf_s3_spikes", sp, 4'b0000);
    get_th(0, t);
    check("rf_s3_th", t, 15);
    do_step(32'h0000_00C8, sp);
    check("rf_s4_spikes", sp, 4'b0001);
    get_th(0, t);
    check("rf_s4_th", t, 19);
`else
    do_step(32'h0000_00C8, sp);
    check("nr_s2_spikes", sp, 4'b0001);
    get_th(0, t);
    check("nr_s2_th", t, 24);
    do_step(32'h0000_00C8, sp);
    check("nr_s3_spikes", sp, 4'b0001);
    get_th(0, t);
    check("nr_s3_th", t, 28);
    do_step(32'h0000_00C8, sp);
    check("nr_s4_spikes", sp, 4'b0001);
`endif

    // Soft clear keeps the published spike vector
    pulse_clr();
    check("clr_keeps_spikes", bus.out_spikes, 4'b0001);
    get_th(0, t);
    check("clr_th0_again", t, 16);

`ifndef LSNN_REFRACTORY_EN
    // Neuron 2, x=255 for 70 steps: spikes every step, threshold saturates at 255
    spike_cnt = 0;
    for (int s = 1; s <= 70; s++) begin
      do_step(32'h00FF_0000, sp);
      if (sp[2]) spike_cnt++;
      if (s == 1 || s == 2 || s == 59 || s == 60 || s == 70) begin
        get_th(2, t);
        case (s)
          1:       check("sat_th_s1", t, 20);
          2:       check("sat_th_s2", t, 24);
          59:      check("sat_th_s59", t, 252);
          60:      check("sat_th_s60", t, 255);
          default: check("sat_th_s70", t, 255);
        endcase
      end
    end
    check("sat_spike_count", spike_cnt, 70);
    check("sat_last_spikes", sp, 4'b0100);
`endif

    // Load v0 = 10, then abort a timestep with reset
    do_step(32'h0000_000A, sp);
    check("pre_rst_spikes", sp, 4'b0000);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_spikes", bus.out_spikes, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    ov_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen = 1'b1;
    end
    check("midrst_no_out_valid", ov_seen, 0);
    for (int i = 0; i < N; i++) begin
      get_th(i, t);
      check($sformatf("midrst_th%0d", i), t, 16);
    end
    // A leftover v0 of 10 would make x=15 reach 20 and spike
    do_step(32'h0000_000F, sp);
    check("midrst_v_zero", sp, 4'b0000);
    get_th(0, t);
    check("midrst_th0_after", t, 14);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/lsnn_neuron_array.md
# lsnn_neuron_array

Parametrised array of adaptive leaky integrate-and-fire neurons, the next generation of the single-neuron LSNN tile. It has N channels, a configurable width, a leak, threshold adaptation and an optional refractory period. One shared datapath updates the neurons serially, one per cycle, for each accepted input timestep. The block sits between the spike-input front end and the spike-output port, and exposes any neuron's live threshold for debug.

## Interface
- N_NEURONS, 4: number of neurons (≥1); IDX_W = max(1, $clog2(N_NEURONS))
- WIDTH, 8: membrane, adaptation and input width
- LEAK_SHIFT, 1: membrane decay per step, v − (v >> LEAK_SHIFT)
- B0, 8: base threshold
- A_INIT, 8: adaptation value at reset and at clear
- ADAPT_INC, 4: adaptation increment on spike
- ADAPT_DECAY_SHIFT, 2: adaptation decay per non-spiking step, a − (a >> ADAPT_DECAY_SHIFT)
- REFRACT, 2: refractory steps after a spike (needs LSNN_REFRACTORY_EN)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input timestep valid
- in_ready  out  1  block can accept a timestep
- in_data  in  N_NEURONS*WIDTH  per-neuron input current; neuron i uses bits [i*WIDTH +: WIDTH]
- clr_state  in  1  synchronous soft clear of all neuron state
- out_valid  out  1  one-cycle pulse: out_spikes updated
- out_spikes  out  N_NEURONS  spike vector of the last completed timestep
- th_sel  in  IDX_W  threshold observation select
- th_out  out  WIDTH  threshold of neuron th_sel

## Operation
- Per-neuron registers:
  - v: membrane, WIDTH bits.
  - a: adaptation, WIDTH bits.
  - r: refractory counter, only when LSNN_REFRACTORY_EN is defined.
- Threshold th = sat(B0 + a). Each step uses the pre-update a.
- All additions saturate at 2^WIDTH−1. Subtractions cannot underflow by construction.
- Neuron update for input x:
  - If r > 0: v' = 0, r' = r−1, spike = 0, a' = a − (a >> ADAPT_DECAY_SHIFT).
  - Otherwise let s = sat(x + v − (v >> LEAK_SHIFT)).
  - If s ≥ th (spike): v' = 0, a' = sat(a + ADAPT_INC), r' = REFRACT.
  - If s < th: v' = s, a' = a − (a >> ADAPT_DECAY_SHIFT).
- FSM states:
  - IDLE: in_ready = !clr_state. The handshake in_valid & in_ready registers in_data into a buffer, sets idx = 0 and moves to BUSY.
  - BUSY: at each edge, update neuron idx and write its spike into a shadow vector. When idx = N_NEURONS−1, go to IDLE, load out_spikes from the shadow vector and set out_valid. Otherwise idx++.
- in_ready = 0 in BUSY. in_valid is ignored there; the sender holds its data.
- clr_state in IDLE: at the next edge v = 0, a = A_INIT, r = 0. No timestep is accepted that cycle. out_spikes is kept. clr_state in BUSY is ignored.
- th_out = sat(B0 + a[th_sel]), combinational from registered state. If th_sel ≥ N_NEURONS, th_out = 0.

## Timing
- Reset (asynchronous, rst_n low) sets:
  - state = IDLE, v = 0, a = A_INIT, r = 0
  - out_spikes = 0, out_valid = 0
  - with th_sel = 0 and clr_state = 0: in_ready = 1, th_out = B0 + A_INIT
- Handshake at edge k: neuron i updates at edge k+1+i. out_valid is high for exactly the cycle after edge k+N_NEURONS, and in_ready is high in that same cycle.
- Earliest next accept: edge k+N_NEURONS+1. Throughput is one timestep per N_NEURONS+1 cycles.
- out_spikes is stable between out_valid pulses.
- Reset asserted mid-BUSY aborts the timestep: no out_valid, and all state returns to reset values.

## Configuration
- LSNN_REFRACTORY_EN defined: the r counters exist and REFRACT applies. REFRACT = 0 behaves as no refractory period.
- LSNN_REFRACTORY_EN undefined: no r registers, r is treated as 0, and a neuron may spike on consecutive steps. REFRACT is ignored.

## Test plan
All scenarios use default parameters.
- Reset with th_sel = 0 → th_out = 16, in_ready = 1, out_spikes = 0, out_valid = 0.
- Neuron 0, x = 5 once, handshake at edge k → out_valid only in the cycle after edge k+4, out_spikes[0] = 0, th_out = 14 (a = 6), in_ready low during BUSY.
- With LSNN_REFRACTORY_EN, neuron 0: x = 20, then x = 200 for three steps:
  - step 1: spike, th_out = 20
  - steps 2–3: no spike, th_out = 17 then 15
  - step 4: spike
- Without LSNN_REFRACTORY_EN, neuron 2, x = 255 for 70 steps → spike every step; a climbs 8, 12, … and saturates at 255; th_out holds at 255 with no wrap.
- Mid-operation control:
  - rst_n pulsed low two cycles after accept → no out_valid, all state at reset values.
  - clr_state and in_valid high together in IDLE → in_ready = 0, no accept, a = 8 and v = 0 everywhere.
